// File: rtl/icap_pkg.sv
// Shared constants, helpers and state type for the ICAP configuration-register reader.
package icap_pkg;

  localparam logic [15:0] WordDummy  = 16'hFFFF;
  localparam logic [15:0] WordSync0  = 16'hAA99;
  localparam logic [15:0] WordSync1  = 16'h5566;
  localparam logic [15:0] WordNoop   = 16'h2000;
  localparam logic [15:0] WordCmdHdr = 16'h30A1;
  localparam logic [15:0] WordDesync = 16'h000D;

  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;

  localparam logic [5:0] RegStat     = 6'h08;
  localparam logic [5:0] RegIdcode   = 6'h0E;
  localparam logic [5:0] RegGeneral1 = 6'h13;
  localparam logic [5:0] RegGeneral2 = 6'h14;
  localparam logic [5:0] RegGeneral3 = 6'h15;
  localparam logic [5:0] RegGeneral4 = 6'h16;
  localparam logic [5:0] RegBootsts  = 6'h20;

  typedef enum logic [2:0] {
    StIdle, StWseq, StTurn1, StRwait, StTurn2, StDseq, StFin
  } state_e;

  // Type-1 packet header, word count fixed at one.
  function automatic logic [15:0] hdr_type1(input logic [1:0] op, input logic [5:0] adr);
    return {3'b001, op, adr, 5'd1};
  endfunction

  // ICAP expects each byte bit-reversed; the mapping is its own inverse.
  function automatic logic [15:0] byte_swap(input logic [15:0] x);
    logic [15:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i]     = x[7-i];
      y[8 + i] = x[15-i];
    end
    return y;
  endfunction

endpackage

// File: rtl/icap_reg_reader_if.sv
// Request/response and ICAP pin bundle for icap_reg_reader.
interface icap_reg_reader_if;
  logic        start;
  logic [5:0]  regadr;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        err;
  logic        icap_ce;
  logic        icap_write;
  logic [15:0] icap_i;
  logic [15:0] icap_o;
  logic        icap_busy;

  modport slave (
    input  start, regadr, icap_o, icap_busy,
    output busy, done, rdata, err, icap_ce, icap_write, icap_i
  );

  modport master (
    output start, regadr, icap_o, icap_busy,
    input  busy, done, rdata, err, icap_ce, icap_write, icap_i
  );
endinterface

// File: rtl/icap_rd_seqrom.sv
// Logical (unswapped) command words for the sync/read-header and desync sequences.
module icap_rd_seqrom
  import icap_pkg::*;
(
  input  state_e      phase_i,
  input  logic [2:0]  idx_i,
  input  logic [5:0]  regadr_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = WordNoop;
    if (phase_i == StWseq) begin
      case (idx_i)
        3'd0:    word_o = WordDummy;
        3'd1:    word_o = WordSync0;
        3'd2:    word_o = WordSync1;
        3'd4:    word_o = hdr_type1(OpRead, regadr_i);
        default: word_o = WordNoop;
      endcase
    end else if (phase_i == StDseq) begin
      case (idx_i)
        3'd0:    word_o = WordCmdHdr;
        3'd1:    word_o = WordDesync;
        default: word_o = WordNoop;
      endcase
    end
  end

endmodule

// File: rtl/icap_reg_reader.sv
// Reads one configuration register through ICAP (state on falling CLK edge).
// Optional read-wait abort enabled by defining ICAPRD_TIMEOUT_EN.
module icap_reg_reader
  import icap_pkg::*;
#(
  parameter logic [7:0] TOUT = 8'd255
) (
  input logic             clk,
  input logic             reset_n,
  icap_reg_reader_if.slave bus
);

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [5:0]  adr_q;
  state_e      rom_phase;
  logic [2:0]  rom_idx;
  logic [15:0] rom_word;

  // Look one word ahead so ICAP_I is registered on the edge that enters each slot.
  always_comb begin
    rom_phase = StWseq;
    rom_idx   = 3'd0;
    case (state_q)
      StWseq:  rom_idx = idx_q + 3'd1;
      StTurn2: rom_phase = StDseq;
      StDseq: begin
        rom_phase = StDseq;
        rom_idx   = idx_q + 3'd1;
      end
      default: ;
    endcase
  end

  icap_rd_seqrom u_seqrom (
    .phase_i  (rom_phase),
    .idx_i    (rom_idx),
    .regadr_i (adr_q),
    .word_o   (rom_word)
  );

`ifdef ICAPRD_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
  assign bus.err = err_q;
`else
  logic unused_tout;
  assign bus.err     = 1'b0;
  assign unused_tout = ^TOUT;
`endif

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      idx_q          <= 3'd0;
      adr_q          <= 6'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.rdata      <= 16'h0000;
      bus.icap_ce    <= 1'b1;
      bus.icap_write <= 1'b0;
      bus.icap_i     <= 16'h0000;
`ifdef ICAPRD_TIMEOUT_EN
      cnt_q          <= 8'd0;
      err_q          <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            adr_q          <= bus.regadr;
            bus.busy       <= 1'b1;
            bus.icap_ce    <= 1'b0;
            bus.icap_write <= 1'b0;
            bus.icap_i     <= byte_swap(rom_word);
            idx_q          <= 3'd0;
            state_q        <= StWseq;
`ifdef ICAPRD_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
          end
        end
        StWseq: begin
          if (idx_q == 3'd6) begin
            bus.icap_ce <= 1'b1;
            bus.icap_i  <= 16'h0000;
            idx_q       <= 3'd0;
            state_q     <= StTurn1;
          end else begin
            bus.icap_i <= byte_swap(rom_word);
            idx_q      <= idx_q + 3'd1;
          end
        end
        StTurn1: begin
          // WRITE flips only while CE is deasserted.
          if (idx_q == 3'd0) begin
            bus.icap_write <= 1'b1;
            idx_q          <= 3'd1;
          end else begin
            bus.icap_ce <= 1'b0;
            idx_q       <= 3'd0;
            state_q     <= StRwait;
`ifdef ICAPRD_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
          end
        end
        StRwait: begin
          if (!bus.icap_busy) begin
            bus.rdata   <= byte_swap(bus.icap_o);
            bus.icap_ce <= 1'b1;
            idx_q       <= 3'd0;
            state_q     <= StTurn2;
          end
`ifdef ICAPRD_TIMEOUT_EN
          else if (cnt_q == TOUT - 8'd1) begin
            bus.rdata   <= 16'hFFFF;
            err_q       <= 1'b1;
            bus.icap_ce <= 1'b1;
            idx_q       <= 3'd0;
            state_q     <= StTurn2;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        StTurn2: begin
          if (idx_q == 3'd0) begin
            bus.icap_write <= 1'b0;
            idx_q          <= 3'd1;
          end else begin
            bus.icap_ce <= 1'b0;
            bus.icap_i  <= byte_swap(rom_word);
            idx_q       <= 3'd0;
            state_q     <= StDseq;
          end
        end
        StDseq: begin
          if (idx_q == 3'd3) begin
            bus.icap_ce <= 1'b1;
            bus.icap_i  <= 16'h0000;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            idx_q       <= 3'd0;
            state_q     <= StFin;
          end else begin
            bus.icap_i <= byte_swap(rom_word);
            idx_q      <= idx_q + 3'd1;
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
